// File: rtl/prescaled_updown_counter.sv
// Up/down counter with a synchronised enable, clock prescaler, programmable modulus,
// synchronous load, wrap or saturate behaviour, terminal-count pulse and sticky overflow.
module prescaled_updown_counter #(
  parameter int              WIDTH    = 16,
  parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
  parameter int              PRESCALE = 1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             switch,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);

  // Load value limited to the modulus; the extra bit keeps the compare exact at WIDTH=32.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] x;
    x = {1'b0, v};
    if (x > MAX_X) x = MAX_X;
    return WIDTH'(x);
  endfunction

  function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH:0] c, input logic d);
    logic [WIDTH:0] x;
    if (!d) x = (c >= MAX_X) ? (SATURATE ? MAX_X : '0) : c + ONE_X;
    else    x = (c == '0)    ? (SATURATE ? '0 : MAX_X) : c - ONE_X;
    return WIDTH'(x);
  endfunction

  logic sync_p0;
  logic en_s;
  logic step;

  // Enable synchroniser: switch is asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      en_s    <= 1'b0;
    end else begin
      sync_p0 <= switch;
      en_s    <= sync_p0;
    end
  end

  generate
    if (PRESCALE > 1) begin : g_pre
      localparam int            PW       = $clog2(PRESCALE);
      localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
      logic [PW-1:0] pre_cnt;

      // Prescale phase holds while disabled and restarts on load.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pre_cnt <= '0;
        end else if (load) begin
          pre_cnt <= '0;
        end else if (en_s) begin
          pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
        end
      end

      assign step = en_s && (pre_cnt == PRE_LAST);
    end else begin : g_nopre
      assign step = en_s;
    end
  endgenerate

  logic [WIDTH:0]   cnt_x;
  logic [WIDTH-1:0] nxt;
  logic             at_limit;
  logic             limit_event;

  assign cnt_x       = {1'b0, count};
  assign at_limit    = dir ? (cnt_x == '0) : (cnt_x >= MAX_X);
  assign limit_event = step && !load && at_limit;

  always_comb begin
    nxt = count;
    if (load)      nxt = clamp_load(load_value);
    else if (step) nxt = step_value(cnt_x, dir);
  end

  // Count/flag register: tc lines up with the wrapped (or held) count value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= nxt;
      tc    <= limit_event;
      if (limit_event)    ovf <= 1'b1;
      else if (clear_ovf) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Scoreboard bench: three counter configurations share one stimulus stream and are
// compared cycle by cycle against a behavioural model of the counting rules.
module tb_prescaled_updown_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        switch = 1'b0;
  logic        dir = 1'b0;
  logic        load = 1'b0;
  logic        clear_ovf = 1'b0;
  logic [15:0] load_value = '0;

  logic [3:0]  count_a, count_b;
  logic [15:0] count_c;
  logic        tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c;

  always #5 clk = ~clk;

  prescaled_updown_counter #(.WIDTH(4), .MAX(9), .PRESCALE(3), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .switch(switch), .dir(dir), .load(load),
    .load_value(load_value[3:0]), .clear_ovf(clear_ovf),
    .count(count_a), .tc(tc_a), .ovf(ovf_a));

  prescaled_updown_counter #(.WIDTH(4), .MAX(9), .PRESCALE(2), .SATURATE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .switch(switch), .dir(dir), .load(load),
    .load_value(load_value[3:0]), .clear_ovf(clear_ovf),
    .count(count_b), .tc(tc_b), .ovf(ovf_b));

  prescaled_updown_counter #(.WIDTH(16)) dut_c (
    .clk(clk), .rst(rst), .switch(switch), .dir(dir), .load(load),
    .load_value(load_value), .clear_ovf(clear_ovf),
    .count(count_c), .tc(tc_c), .ovf(ovf_c));

  typedef logic [2:0][17:0] exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int fails  = 0;

  int MX[3]  = '{9, 9, 65535};
  int PS[3]  = '{3, 2, 1};
  bit SAT[3] = '{1'b0, 1'b1, 1'b0};
  int MSK[3] = '{15, 15, 65535};

  int m_cnt[3];
  bit m_ovf[3];
  int m_ph[3];
  bit h1, h2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
    end
  endtask

  // Model of one rising edge using the inputs currently applied.
  task automatic model_edge(output exp_t e);
    bit en, stp, lim, tcv;
    int v;
    en = h2;
    for (int k = 0; k < 3; k++) begin
      tcv = 1'b0;
      if (rst) begin
        m_cnt[k] = 0; m_ovf[k] = 1'b0; m_ph[k] = 0;
      end else begin
        stp = 1'b0;
        if (load) begin
          v = int'(load_value) & MSK[k];
          m_cnt[k] = (v > MX[k]) ? MX[k] : v;
          m_ph[k] = 0;
        end else begin
          if (en) m_ph[k]++;
          stp = en && (m_ph[k] % PS[k] == 0);
        end
        if (stp) begin
          lim = dir ? (m_cnt[k] == 0) : (m_cnt[k] == MX[k]);
          if (lim) begin
            tcv = 1'b1;
            if (!SAT[k]) m_cnt[k] = dir ? MX[k] : 0;
          end else begin
            m_cnt[k] = dir ? m_cnt[k] - 1 : m_cnt[k] + 1;
          end
        end
        if (clear_ovf) m_ovf[k] = 1'b0;
        if (tcv) m_ovf[k] = 1'b1;
      end
      e[k] = {m_cnt[k][15:0], tcv, m_ovf[k]};
    end
    if (rst) begin
      h1 = 1'b0; h2 = 1'b0;
    end else begin
      h2 = h1; h1 = switch;
    end
  endtask

  // Called just after a falling edge; applies one cycle of stimulus.
  task automatic drive(input bit r, input bit sw, input bit d, input bit ld,
                       input logic [15:0] lv, input bit clr, input bit glitch);
    exp_t e;
    bit was_rst;
    was_rst    = rst;
    switch     = sw;
    dir        = d;
    load       = ld;
    load_value = lv;
    clear_ovf  = clr;
    rst        = r;
    if (r && !was_rst) begin
      #1;
      chk("async_rst count_a", 32'(count_a), 0);
      chk("async_rst count_b", 32'(count_b), 0);
      chk("async_rst count_c", 32'(count_c), 0);
      chk("async_rst tc", {29'd0, tc_a, tc_b, tc_c}, 0);
      chk("async_rst ovf", {29'd0, ovf_a, ovf_b, ovf_c}, 0);
    end
    model_edge(e);
    exp_q.push_back(e);
    if (glitch) begin
      #1 switch = ~sw;
      #2 switch = sw;
    end
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a[0] = {12'd0, count_a, tc_a, ovf_a};
        a[1] = {12'd0, count_b, tc_b, ovf_b};
        a[2] = {count_c, tc_c, ovf_c};
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("count[%0d]", k), 32'(a[k][17:2]), 32'(e[k][17:2]));
          chk($sformatf("tc[%0d]", k),    32'(a[k][1]),    32'(e[k][1]));
          chk($sformatf("ovf[%0d]", k),   32'(a[k][0]),    32'(e[k][0]));
        end
      end
    end
  end

  initial begin : stimulus
    bit dcur, r, sw, ld, clr, gl;
    logic [15:0] lv;
    int guard;
    h1 = 1'b0; h2 = 1'b0;
    @(negedge clk);
    repeat (2) drive(1, 0, 0, 0, 16'h0, 0, 0);
    drive(0, 0, 0, 1, 16'h0123, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 16'h0, 0, 0);
    repeat (40) drive(0, 1, 0, 0, 16'h0, 0, 0);
    drive(1, 1, 0, 0, 16'h0, 0, 0);
    repeat (12) drive(0, 1, 0, 0, 16'h0, 0, 0);
    drive(0, 1, 1, 1, 16'h0, 0, 0);
    repeat (12) drive(0, 1, 1, 0, 16'h0, 0, 0);
    drive(0, 1, 0, 1, 16'h8, 0, 0);
    repeat (14) drive(0, 1, 0, 0, 16'h0, 0, 0);
    drive(0, 1, 0, 1, 16'hFFFF, 0, 0);
    repeat (6) drive(0, 1, 0, 0, 16'h0, 1, 0);
    repeat (3) drive(0, 1, 1, 0, 16'h0, 1, 0);
    drive(0, 0, 1, 0, 16'h0, 0, 0);
    repeat (8) drive(0, 1, 1, 0, 16'h0, 0, 0);
    repeat (6) drive(0, 0, 1, 0, 16'h0, 0, 1);
    dcur = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      sw  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) dcur = ~dcur;
      ld  = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 5))
        0: lv = 16'h0;
        1: lv = 16'h9;
        2: lv = 16'hF;
        3: lv = 16'hFFFE;
        4: lv = 16'h0001;
        default: lv = 16'($urandom);
      endcase
      clr = ($urandom_range(0, 19) == 0);
      gl  = ($urandom_range(0, 24) == 0);
      drive(r, sw, dcur, ld, lv, clr, gl);
    end
    drive(0, 0, 0, 0, 16'h0, 0, 0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    chk("scoreboard drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
